multicycle_ctrl: RTL

//  Moore FSM sequencing the multicycle CPU datapath of Proyecto4.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle CPU controller.
//   - opcode values recognised by the decoder
//   - FSM state encoding
//   - alu_op and pc_src select codes
//   - op_legal(): true for every opcode the datapath can execute
package ctrl_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_R    = 6'h00;
    localparam logic [OP_W-1:0] OP_J    = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
    localparam logic [OP_W-1:0] OP_LW   = 6'h23;
    localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_SEQ = 2'd0;   // pc + 4
    localparam logic [1:0] PC_BR  = 2'd1;   // branch target register
    localparam logic [1:0] PC_JMP = 2'd2;   // jump target

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_R)  || (op == OP_J)  || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: watchdog for memory accesses.
//   clk, rst_n  clock, synchronous active-low reset
//   clear       zero the count (asserted whenever a new wait begins)
//   count_en    one more cycle spent waiting on memory
//   expired     this cycle's wait brings the count to TIMEOUT
// expired is combinational so the controller can trap on the very cycle the
// limit is reached; since it requires count_en, a ready on that same cycle
// suppresses it. TIMEOUT = 0 disables the watchdog.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Count only needs to reach TIMEOUT-1; the trap fires on the next increment.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (count_en)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && count_en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multicycle CPU datapath.
// Inputs : clk, rst_n (sync, active low), en, opcode, zero (ALU flag),
//          mem_ready (memory finishes current access this cycle).
// Outputs: memory strobes (mem_rd/mem_wr), register loads (ir_we, pc_we,
//          tgt_we, rf_we), mux selects (pc_src, sel_operb, imm_sel, alu_op,
//          rf_wsel), sticky traps (illegal, timeout) and busy.
// Strobes are decoded from the registered state; opcode qualifies EXEC/MEM/WB,
// and mem_ready/zero qualify the load strobes that complete a step.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int          OPCODE_W = 6,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                sel_operb,
    output logic                imm_sel,
    output logic [1:0]          alu_op,
    output logic                tgt_we,
    output logic                rf_we,
    output logic                rf_wsel,
    output logic                illegal,
    output logic                timeout,
    output logic                busy
);

    state_t          state, state_nxt;
    logic [OP_W-1:0] op;
    logic            legal;
    logic            wait_st, count_en, clear, expired;
    logic            illegal_q, timeout_q;
    state_t          next_fetch;

    assign op    = OP_W'(opcode);
    assign legal = op_legal(op);

    // Watchdog runs only while waiting on memory; any state change restarts it,
    // which covers the direct MEM -> FETCH hop after a store.
    assign wait_st  = (state == S_FETCH) || (state == S_MEM);
    assign count_en = wait_st && !mem_ready;
    assign clear    = !wait_st || (state_nxt != state);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .count_en (count_en),
        .expired  (expired)
    );

    // A dropped enable parks the controller at the instruction boundary.
    assign next_fetch = en ? S_FETCH : S_IDLE;

    // State register and sticky trap flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE && !legal)
                illegal_q <= 1'b1;
            if (expired)
                timeout_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (en) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (expired) state_nxt = S_TRAP;
            end
            S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (op == OP_R || op == OP_ADDI)     state_nxt = S_WB;
                else if (op == OP_LW || op == OP_SW) state_nxt = S_MEM;
                else                                 state_nxt = next_fetch;
            end
            S_MEM: begin
                if (mem_ready)    state_nxt = (op == OP_LW) ? S_WB : next_fetch;
                else if (expired) state_nxt = S_TRAP;
            end
            S_WB:     state_nxt = next_fetch;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SEQ;
        sel_operb = 1'b0;
        imm_sel   = 1'b0;
        alu_op    = ALU_ADD;
        tgt_we    = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            // Speculatively compute pc + imm into the branch-target register.
            S_DECODE: begin
                sel_operb = 1'b1;
                imm_sel   = 1'b1;
                tgt_we    = 1'b1;
            end
            S_EXEC: begin
                if (op == OP_R) begin
                    alu_op = ALU_FUNCT;
                end else if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
                    imm_sel = 1'b1;
                end else if (op == OP_BEQ) begin
                    alu_op = ALU_SUB;
                    pc_we  = zero;
                    pc_src = zero ? PC_BR : PC_SEQ;
                end else if (op == OP_J) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JMP;
                end
            end
            S_MEM: begin
                mem_rd = (op == OP_LW);
                mem_wr = (op == OP_SW);
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = (op == OP_LW);
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign busy    = (state != S_IDLE) && (state != S_TRAP);

endmodule
